// File: rtl/execute_memory_latch.sv
// execute_memory_latch: EX/MEM pipeline register for the 5-stage MIPS core.
// Captures ALU result, store data and memory/writeback control each enabled
// edge. Store data is pre-masked to the access width, misaligned memory
// accesses are squashed, HALT is latched until reset, and captured
// instructions are counted.
//
// Handshake: there is no valid/ready pair. i_enable acts as a global advance
// strobe from the debug unit: low freezes every register (including the FSM),
// high lets the stage advance by exactly one instruction or bubble.
module execute_memory_latch #(
  parameter int NB_DATA        = 32,
  parameter int NB_REG_ADDRESS = 5,
  parameter int NB_MASK        = 2,
  parameter int NB_COUNTER     = 32
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic                      i_flush,
  input  logic [NB_DATA-1:0]        i_alu_result,
  input  logic [NB_DATA-1:0]        i_store_data,
  input  logic [NB_MASK-1:0]        i_data_mask,
  input  logic                      i_is_unsigned,
  input  logic                      i_mem_write,
  input  logic                      i_mem_to_reg,
  input  logic                      i_reg_write,
  input  logic [NB_REG_ADDRESS-1:0] i_rd,
  input  logic                      i_halt,
  output logic [NB_DATA-1:0]        o_memory_address,
  output logic [NB_DATA-1:0]        o_data_write,
  output logic [NB_MASK-1:0]        o_data_mask,
  output logic                      o_is_unsigned,
  output logic                      o_mem_write,
  output logic                      o_mem_to_reg,
  output logic                      o_reg_write,
  output logic [NB_REG_ADDRESS-1:0] o_rd,
  output logic                      o_halt,
  output logic                      o_misaligned,
  output logic [NB_COUNTER-1:0]     o_instr_count,
  output logic                      o_dbg_state
);

  // Access-size codes; 10 is decoded as a word access.
  localparam logic [NB_MASK-1:0] MASK_BYTE = NB_MASK'(0);
  localparam logic [NB_MASK-1:0] MASK_HALF = NB_MASK'(1);
  localparam logic [NB_MASK-1:0] MASK_WRDA = NB_MASK'(2);
  localparam logic [NB_MASK-1:0] MASK_WORD = NB_MASK'(3);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  state_e                      state_q,         state_d;
  logic [NB_DATA-1:0]          memory_address_q, memory_address_d;
  logic [NB_DATA-1:0]          data_write_q,    data_write_d;
  logic [NB_MASK-1:0]          data_mask_q,     data_mask_d;
  logic                        is_unsigned_q,   is_unsigned_d;
  logic                        mem_write_q,     mem_write_d;
  logic                        mem_to_reg_q,    mem_to_reg_d;
  logic                        reg_write_q,     reg_write_d;
  logic [NB_REG_ADDRESS-1:0]   rd_q,            rd_d;
  logic                        halt_q,          halt_d;
  logic                        misaligned_q,    misaligned_d;
  logic [NB_COUNTER-1:0]       instr_count_q,   instr_count_d;

  logic [NB_DATA-1:0]          store_masked;
  logic                        misaligned_now;

  // Store data masking and alignment check for the incoming instruction.
  always_comb begin
    store_masked   = '0;
    misaligned_now = 1'b0;
    case (i_data_mask)
      MASK_BYTE: store_masked[7:0]  = i_store_data[7:0];
      MASK_HALF: store_masked[15:0] = i_store_data[15:0];
      default:   store_masked       = i_store_data;
    endcase
    if (i_mem_write || i_mem_to_reg) begin
      case (i_data_mask)
        MASK_HALF:            misaligned_now = i_alu_result[0];
        MASK_WORD, MASK_WRDA: misaligned_now = |i_alu_result[1:0];
        default:              misaligned_now = 1'b0;
      endcase
    end
  end

  // Next-state: stall holds, halted/flush loads a bubble, otherwise capture.
  always_comb begin
    state_d          = state_q;
    memory_address_d = memory_address_q;
    data_write_d     = data_write_q;
    data_mask_d      = data_mask_q;
    is_unsigned_d    = is_unsigned_q;
    mem_write_d      = mem_write_q;
    mem_to_reg_d     = mem_to_reg_q;
    reg_write_d      = reg_write_q;
    rd_d             = rd_q;
    halt_d           = halt_q;
    misaligned_d     = misaligned_q;
    instr_count_d    = instr_count_q;

    if (i_enable) begin
      if ((state_q == ST_HALTED) || i_flush) begin
        // Bubble: every payload/control field cleared; sticky flags kept.
        memory_address_d = '0;
        data_write_d     = '0;
        data_mask_d      = '0;
        is_unsigned_d    = 1'b0;
        mem_write_d      = 1'b0;
        mem_to_reg_d     = 1'b0;
        reg_write_d      = 1'b0;
        rd_d             = '0;
      end else begin
        memory_address_d = i_alu_result;
        data_write_d     = store_masked;
        data_mask_d      = i_data_mask;
        is_unsigned_d    = i_is_unsigned;
        rd_d             = i_rd;
        // A misaligned access still travels down the pipe but has no effect.
        mem_write_d      = i_mem_write  & ~misaligned_now;
        mem_to_reg_d     = i_mem_to_reg & ~misaligned_now;
        reg_write_d      = i_reg_write  & ~misaligned_now;
        misaligned_d     = misaligned_q | misaligned_now;
        instr_count_d    = instr_count_q + NB_COUNTER'(1);
        if (i_halt) begin
          halt_d  = 1'b1;
          state_d = ST_HALTED;
        end
      end
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q          <= ST_RUN;
      memory_address_q <= '0;
      data_write_q     <= '0;
      data_mask_q      <= '0;
      is_unsigned_q    <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_to_reg_q     <= 1'b0;
      reg_write_q      <= 1'b0;
      rd_q             <= '0;
      halt_q           <= 1'b0;
      misaligned_q     <= 1'b0;
      instr_count_q    <= '0;
    end else begin
      state_q          <= state_d;
      memory_address_q <= memory_address_d;
      data_write_q     <= data_write_d;
      data_mask_q      <= data_mask_d;
      is_unsigned_q    <= is_unsigned_d;
      mem_write_q      <= mem_write_d;
      mem_to_reg_q     <= mem_to_reg_d;
      reg_write_q      <= reg_write_d;
      rd_q             <= rd_d;
      halt_q           <= halt_d;
      misaligned_q     <= misaligned_d;
      instr_count_q    <= instr_count_d;
    end
  end

  assign o_memory_address = memory_address_q;
  assign o_data_write     = data_write_q;
  assign o_data_mask      = data_mask_q;
  assign o_is_unsigned    = is_unsigned_q;
  assign o_mem_write      = mem_write_q;
  assign o_mem_to_reg     = mem_to_reg_q;
  assign o_reg_write      = reg_write_q;
  assign o_rd             = rd_q;
  assign o_halt           = halt_q;
  assign o_misaligned     = misaligned_q;
  assign o_instr_count    = instr_count_q;
  assign o_dbg_state      = state_q;

endmodule

// File: tb/tb_execute_memory_latch.sv
// Directed bench for execute_memory_latch with hand-computed expectations.
module tb_execute_memory_latch;

  // ---------------- clock / reset ----------------
  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_enable;
  logic        i_flush;
  logic [31:0] i_alu_result;
  logic [31:0] i_store_data;
  logic [1:0]  i_data_mask;
  logic        i_is_unsigned;
  logic        i_mem_write;
  logic        i_mem_to_reg;
  logic        i_reg_write;
  logic [4:0]  i_rd;
  logic        i_halt;
  logic [31:0] o_memory_address;
  logic [31:0] o_data_write;
  logic [1:0]  o_data_mask;
  logic        o_is_unsigned;
  logic        o_mem_write;
  logic        o_mem_to_reg;
  logic        o_reg_write;
  logic [4:0]  o_rd;
  logic        o_halt;
  logic        o_misaligned;
  logic [31:0] o_instr_count;
  logic        o_dbg_state;

  always #5 i_clock = ~i_clock;

  execute_memory_latch dut (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .i_enable         (i_enable),
    .i_flush          (i_flush),
    .i_alu_result     (i_alu_result),
    .i_store_data     (i_store_data),
    .i_data_mask      (i_data_mask),
    .i_is_unsigned    (i_is_unsigned),
    .i_mem_write      (i_mem_write),
    .i_mem_to_reg     (i_mem_to_reg),
    .i_reg_write      (i_reg_write),
    .i_rd             (i_rd),
    .i_halt           (i_halt),
    .o_memory_address (o_memory_address),
    .o_data_write     (o_data_write),
    .o_data_mask      (o_data_mask),
    .o_is_unsigned    (o_is_unsigned),
    .o_mem_write      (o_mem_write),
    .o_mem_to_reg     (o_mem_to_reg),
    .o_reg_write      (o_reg_write),
    .o_rd             (o_rd),
    .o_halt           (o_halt),
    .o_misaligned     (o_misaligned),
    .o_instr_count    (o_instr_count),
    .o_dbg_state      (o_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] data, input logic [1:0] mask,
                       input logic uns, input logic mw, input logic mr, input logic rw,
                       input logic [4:0] rd, input logic halt);
    i_alu_result  = alu;
    i_store_data  = data;
    i_data_mask   = mask;
    i_is_unsigned = uns;
    i_mem_write   = mw;
    i_mem_to_reg  = mr;
    i_reg_write   = rw;
    i_rd          = rd;
    i_halt        = halt;
  endtask

  // Checks every payload/control output against a bubble (all zero).
  task automatic check_bubble(input string tag);
    check_val({tag, "_addr"}, o_memory_address, 32'h0);
    check_val({tag, "_data"}, o_data_write, 32'h0);
    check_val({tag, "_ctl"}, {24'h0, o_data_mask, o_is_unsigned, o_mem_write,
                              o_mem_to_reg, o_reg_write, 2'b00}, 32'h0);
    check_val({tag, "_rd"}, {27'h0, o_rd}, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    logic [31:0] frozen_addr;
    i_reset  = 1'b1;
    i_enable = 1'b1;
    i_flush  = 1'b0;
    drive(32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    tick();
    check_bubble("reset");
    check_val("reset_halt", {31'h0, o_halt}, 32'h0);
    check_val("reset_mis", {31'h0, o_misaligned}, 32'h0);
    check_val("reset_cnt", o_instr_count, 32'd0);
    check_val("reset_state", {31'h0, o_dbg_state}, 32'h0);

    // Word load.
    i_reset = 1'b0;
    drive(32'h10, 32'h0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0);
    tick();
    check_val("ld_addr", o_memory_address, 32'h10);
    check_val("ld_m2r", {31'h0, o_mem_to_reg}, 32'h1);
    check_val("ld_rd", {27'h0, o_rd}, 32'd5);
    check_val("ld_cnt", o_instr_count, 32'd1);

    // Byte store to odd address: never misaligned.
    drive(32'h3, 32'hAABBCCDD, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    check_val("sb_data", o_data_write, 32'h000000DD);
    check_val("sb_mw", {31'h0, o_mem_write}, 32'h1);
    check_val("sb_mis", {31'h0, o_misaligned}, 32'h0);

    // Halfword store, aligned.
    drive(32'h2, 32'hAABBCCDD, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    check_val("sh_data", o_data_write, 32'h0000CCDD);
    check_val("sh_mw", {31'h0, o_mem_write}, 32'h1);

    // Mask 10 behaves as a word: full data, aligned at 0x4.
    drive(32'h4, 32'hAABBCCDD, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    check_val("sw10_data", o_data_write, 32'hAABBCCDD);
    check_val("sw10_mw", {31'h0, o_mem_write}, 32'h1);
    check_val("sw10_mask", {30'h0, o_data_mask}, 32'h2);
    check_val("sw10_cnt", o_instr_count, 32'd4);

    // Misaligned word load at 0x6: squashed, still captured and counted.
    drive(32'h6, 32'h0, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0);
    tick();
    check_val("mis_ctl", {29'h0, o_mem_write, o_mem_to_reg, o_reg_write}, 32'h0);
    check_val("mis_addr", o_memory_address, 32'h6);
    check_val("mis_rd", {27'h0, o_rd}, 32'd7);
    check_val("mis_flag", {31'h0, o_misaligned}, 32'h1);
    check_val("mis_cnt", o_instr_count, 32'd5);

    // Ten valid ALU ops: sticky flag held, expected counts queued.
    for (int k = 0; k < 10; k++) exp_q.push_back(32'd6 + 32'(k));
    for (int k = 0; k < 10; k++) begin
      drive(32'h100 + 32'(k), 32'h0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 5'(k + 1), 1'b0);
      tick();
      check_val("hold_mis", {31'h0, o_misaligned}, 32'h1);
      check_val("hold_rw", {31'h0, o_reg_write}, 32'h1);
      check_val("hold_cnt", o_instr_count, exp_q.pop_front());
    end

    // Misaligned halfword store at 0x1.
    drive(32'h1, 32'h12345678, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    check_val("mish_mw", {31'h0, o_mem_write}, 32'h0);
    check_val("mish_data", o_data_write, 32'h00005678);
    check_val("mish_cnt", o_instr_count, 32'd16);

    // Stall 3 cycles with changing inputs and flush high.
    frozen_addr = 32'h1;
    i_enable = 1'b0;
    i_flush  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(32'h2000 + 32'(k), 32'hFFFFFFFF, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 1'b1);
      tick();
      check_val("stall_addr", o_memory_address, frozen_addr);
      check_val("stall_data", o_data_write, 32'h00005678);
      check_val("stall_cnt", o_instr_count, 32'd16);
      check_val("stall_halt", {31'h0, o_halt}, 32'h0);
    end
    // Re-enable with flush still high: bubble, counter unchanged.
    i_enable = 1'b1;
    tick();
    check_bubble("flush");
    check_val("flush_cnt", o_instr_count, 32'd16);
    check_val("flush_mis", {31'h0, o_misaligned}, 32'h1);
    check_val("flush_halt", {31'h0, o_halt}, 32'h0);
    check_val("flush_state", {31'h0, o_dbg_state}, 32'h0);

    // Flush takes priority over HALT: bubble, still RUN, then capture resumes.
    i_flush = 1'b0;
    drive(32'h44, 32'h0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0);
    tick();
    check_val("resume_addr", o_memory_address, 32'h44);
    check_val("resume_cnt", o_instr_count, 32'd17);

    // Reset, then six instructions and HALT as the seventh.
    i_reset = 1'b1;
    tick();
    check_val("rst2_cnt", o_instr_count, 32'd0);
    check_val("rst2_mis", {31'h0, o_misaligned}, 32'h0);
    i_reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive(32'h20 + 32'(k), 32'h0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 1'b0);
      tick();
    end
    check_val("pre_halt_cnt", o_instr_count, 32'd6);
    drive(32'h80, 32'h0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    tick();
    check_val("halt_flag", {31'h0, o_halt}, 32'h1);
    check_val("halt_cnt", o_instr_count, 32'd7);
    check_val("halt_addr", o_memory_address, 32'h80);
    check_val("halt_state", {31'h0, o_dbg_state}, 32'h1);

    // Valid work after HALT becomes bubbles; count stays 7.
    for (int k = 0; k < 3; k++) begin
      drive(32'h300, 32'h55, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0);
      tick();
      check_bubble("halted");
      check_val("halted_cnt", o_instr_count, 32'd7);
      check_val("halted_flag", {31'h0, o_halt}, 32'h1);
    end

    // Reset leaves HALTED.
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check_bubble("rst3");
    check_val("rst3_halt", {31'h0, o_halt}, 32'h0);
    check_val("rst3_state", {31'h0, o_dbg_state}, 32'h0);
    check_val("rst3_cnt", o_instr_count, 32'd0);

    // Same-edge flush and HALT: bubble, HALT discarded.
    i_flush = 1'b1;
    drive(32'h90, 32'h0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6, 1'b1);
    tick();
    check_bubble("fh");
    check_val("fh_halt", {31'h0, o_halt}, 32'h0);
    check_val("fh_state", {31'h0, o_dbg_state}, 32'h0);
    check_val("fh_cnt", o_instr_count, 32'd0);

    // Next plain instruction still captured (state stayed RUN).
    i_flush = 1'b0;
    drive(32'h94, 32'h0, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0);
    tick();
    check_val("after_fh_addr", o_memory_address, 32'h94);
    check_val("after_fh_uns", {31'h0, o_is_unsigned}, 32'h1);
    check_val("after_fh_cnt", o_instr_count, 32'd1);

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin : watchdog
    #100000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
